// File: rtl/csit_luks.sv
`default_nettype none
// ============================================================================
// Module      : csit_luks
// Description : Exposure/light-meter top. Encoder and button select ISO,
//               shutter and aperture indices; glyphs are fetched from an SPI
//               NOR flash (READ 0x03) and shown on uo_out. EXP_METER gates a
//               light-to-frequency input and displays the EV error glyph.
// Revision    : 1.0 - initial release
// ============================================================================
module csit_luks #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int MEDIUM_CYCLES   = 256,
  parameter int GATE_CYCLES     = 1024,
  parameter int IDX_MAX         = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PR_W = $clog2(MEDIUM_CYCLES + 1);
  localparam int GT_W = $clog2(GATE_CYCLES);
  localparam int PC_W = GT_W + 1;
  // Button input idles high (active low), so its synchronizer resets high.
  localparam logic [4:0] C_SYNC_RST = 5'b00100;
  // SPI frame timing in clocks from the start of a transfer: SCK rises on
  // even counts below C_SCK_END; MISO reaches the sync output two clocks
  // late, so data bits are read on counts C_SAMP0..C_SCK_END.
  localparam logic [6:0] C_SAMP0   = 7'd66;
  localparam logic [6:0] C_SCK_END = 7'd80;
  localparam logic [6:0] C_T_LAST  = 7'd82;

  typedef enum logic [1:0] {ISO_SEL = 2'd0, SS_SEL = 2'd1, F_SEL = 2'd2, EXP_METER = 2'd3} mode_e;
  typedef enum logic [1:0] {FS_IDLE = 2'd0, FS_XFER = 2'd1, FS_DONE = 2'd2} fetch_e;

  logic [4:0]      sync1_q, sync2_q;
  logic            a_prev_q, s_prev_q;
  logic            btn_db_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [PR_W-1:0] press_q;
  mode_e           mode_q, mode_d;
  logic [3:0]      iso_q, ss_q, f_q, ev_q;
  logic            meas_act_q;
  logic [GT_W-1:0] gate_q;
  logic [PC_W-1:0] pcnt_q;
  fetch_e          fst_q, fst_d;
  logic            pend_q, csb_q, sck_q;
  logic [6:0]      t_q;
  logic [39:0]     sr_q;
  logic [7:0]      data_q, uo_q;

  logic a_rise, s_rise, enc_b, btn_s, miso_s, db_fall, short_p, medium_p;
  logic step_up, step_dn, idx_chg, meas_start, meas_abort, meas_done, trig, start;
  logic [3:0] cur_idx, new_idx, ev_now, glyph, fidx;
  logic signed [6:0] gsum;
  logic unused;

  assign unused   = &{1'b0, ena, uio_in, ui_in[7:5]};
  assign enc_b    = sync2_q[1];
  assign btn_s    = ~sync2_q[2];
  assign miso_s   = sync2_q[3];
  assign a_rise   = sync2_q[0] & ~a_prev_q;
  assign s_rise   = sync2_q[4] & ~s_prev_q;
  assign db_fall  = btn_db_q & ~btn_s & (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
  assign short_p  = db_fall & (press_q != PR_W'(MEDIUM_CYCLES));
  assign medium_p = db_fall & (press_q == PR_W'(MEDIUM_CYCLES));

  // Two-flop synchronizers plus edge-detect history for encoder A and sensor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= C_SYNC_RST;
      sync2_q  <= C_SYNC_RST;
      a_prev_q <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      sync1_q  <= ui_in[4:0];
      sync2_q  <= sync1_q;
      a_prev_q <= sync2_q[0];
      s_prev_q <= sync2_q[4];
    end
  end

  // Debounce the button and time how long it is held (saturating).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= '0;
    end else begin
      if (btn_s != btn_db_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db_q <= btn_s;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
      if (!btn_db_q)                             press_q <= '0;
      else if (press_q != PR_W'(MEDIUM_CYCLES))  press_q <= press_q + PR_W'(1);
    end
  end

  // Mode next-state: short press cycles selections, medium enters/leaves metering.
  always_comb begin
    mode_d = mode_q;
    if (short_p) begin
      case (mode_q)
        ISO_SEL: mode_d = SS_SEL;
        SS_SEL:  mode_d = F_SEL;
        F_SEL:   mode_d = ISO_SEL;
        default: mode_d = EXP_METER;
      endcase
    end else if (medium_p) begin
      mode_d = (mode_q == EXP_METER) ? ISO_SEL : EXP_METER;
    end
  end

  // Encoder step decode, EV extraction, glyph clamp and fetch trigger.
  always_comb begin
    case (mode_q)
      ISO_SEL: cur_idx = iso_q;
      SS_SEL:  cur_idx = ss_q;
      default: cur_idx = f_q;
    endcase
    step_up = a_rise & ~enc_b & (mode_q != EXP_METER) & (cur_idx != 4'(IDX_MAX));
    step_dn = a_rise &  enc_b & (mode_q != EXP_METER) & (cur_idx != 4'd0);
    idx_chg = step_up | step_dn;
    new_idx = step_up ? cur_idx + 4'd1 : cur_idx - 4'd1;
    ev_now  = 4'd0;
    for (int i = 0; i < PC_W; i++) begin
      if (pcnt_q[i]) ev_now = 4'(i);
    end
    gsum = $signed({3'b000, ev_q}) + 7'sd8 - $signed({3'b000, f_q})
         + $signed({4'b0000, ss_q[3:1]}) - $signed({4'b0000, iso_q[3:1]});
    if (gsum < 7'sd0)       glyph = 4'd0;
    else if (gsum > 7'sd15) glyph = 4'd15;
    else                    glyph = gsum[3:0];
    fidx       = (mode_q == EXP_METER) ? glyph : cur_idx;
    meas_start = (medium_p & (mode_q != EXP_METER)) | (short_p & (mode_q == EXP_METER));
    meas_abort = medium_p & (mode_q == EXP_METER);
    meas_done  = meas_act_q & (gate_q == GT_W'(GATE_CYCLES - 1)) & ~meas_start & ~meas_abort;
    trig       = idx_chg | (mode_d != mode_q) | meas_done;
  end

  // Mode register, setting indices and the light-measurement gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= ISO_SEL;
      iso_q      <= 4'd0;
      ss_q       <= 4'd0;
      f_q        <= 4'd0;
      ev_q       <= 4'd0;
      meas_act_q <= 1'b0;
      gate_q     <= '0;
      pcnt_q     <= '0;
    end else begin
      mode_q <= mode_d;
      if (idx_chg) begin
        case (mode_q)
          ISO_SEL: iso_q <= new_idx;
          SS_SEL:  ss_q  <= new_idx;
          default: f_q   <= new_idx;
        endcase
      end
      if (meas_start) begin
        meas_act_q <= 1'b1;
        gate_q     <= '0;
        pcnt_q     <= '0;
      end else if (meas_abort) begin
        meas_act_q <= 1'b0;
      end else if (meas_act_q) begin
        gate_q <= gate_q + GT_W'(1);
        if (s_rise) pcnt_q <= pcnt_q + PC_W'(1);
        if (meas_done) begin
          meas_act_q <= 1'b0;
          ev_q       <= ev_now;
        end
      end
    end
  end

  // Fetch sequencer next-state: idle until a trigger is pending, then one frame.
  always_comb begin
    fst_d = fst_q;
    start = 1'b0;
    case (fst_q)
      FS_IDLE: if (pend_q) begin
        start = 1'b1;
        fst_d = FS_XFER;
      end
      FS_XFER: if (t_q == C_T_LAST) fst_d = FS_DONE;
      FS_DONE: fst_d = FS_IDLE;
      default: fst_d = FS_IDLE;
    endcase
  end

  // SPI datapath: latch address at start, shift MOSI on SCK fall, collect MISO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fst_q  <= FS_IDLE;
      pend_q <= 1'b1;
      csb_q  <= 1'b1;
      sck_q  <= 1'b0;
      t_q    <= 7'd0;
      sr_q   <= '0;
      data_q <= 8'd0;
      uo_q   <= 8'd0;
    end else begin
      fst_q  <= fst_d;
      pend_q <= (pend_q & ~start) | trig;
      case (fst_q)
        FS_IDLE: if (start) begin
          sr_q  <= {8'h03, 16'h0000, 2'b00, mode_q, fidx, 8'h00};
          csb_q <= 1'b0;
          t_q   <= 7'd0;
        end
        FS_XFER: begin
          t_q   <= t_q + 7'd1;
          sck_q <= ~t_q[0] & (t_q < C_SCK_END);
          if (t_q[0] && (t_q < C_SCK_END)) sr_q <= {sr_q[38:0], 1'b0};
          if (!t_q[0] && (t_q >= C_SAMP0) && (t_q <= C_SCK_END))
            data_q <= {data_q[6:0], miso_s};
          if (t_q == C_T_LAST) csb_q <= 1'b1;
        end
        FS_DONE: uo_q <= data_q;
        default: ;
      endcase
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {sr_q[39], 1'b0, csb_q, sck_q, 2'b00, mode_q};
  assign uio_oe  = 8'b1011_0011;

endmodule
`default_nettype wire

// File: tb/tb_csit_luks.sv
`default_nettype none
// ============================================================================
// Module      : tb_csit_luks
// Description : Scoreboard bench for csit_luks with a behavioural SPI flash.
//               Stimulus pushes expected fetch addresses; a monitor pops one
//               per completed flash frame and checks cmd, address and glyph.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_csit_luks;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enc_a = 1'b0, enc_b = 1'b0, btn_n = 1'b1, miso = 1'b0, sens = 1'b0;
  logic       sens_en = 1'b0;
  logic [7:0] ui_in, uo_out, uio_out, uio_oe;
  wire        csb  = uio_out[5];
  wire        sck  = uio_out[4];
  wire        mosi = uio_out[7];

  assign ui_in = {3'b000, sens, miso, btn_n, enc_b, enc_a};

  csit_luks dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (1'b1),
    .ui_in  (ui_in),
    .uio_in (8'h00),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] exp_q[$];
  logic [31:0] rx = '0;
  logic [7:0]  fd;
  int          bitcnt = 0;

  // Flash contents: glyph byte as a function of the low address byte.
  function automatic logic [7:0] fdata(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h6C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Behavioural SPI NOR (mode 0): capture cmd+addr on rise, drive data on fall.
  always @(negedge csb) bitcnt = 0;
  always @(posedge sck) if (!csb) begin
    if (bitcnt < 32) rx = {rx[30:0], mosi};
    bitcnt++;
  end
  always @(negedge sck) if (!csb && bitcnt >= 32 && bitcnt < 40) begin
    fd   = fdata(rx[7:0]);
    miso = fd[39 - bitcnt];
  end

  // Light sensor: square wave with a 20-clock period while enabled.
  initial forever begin
    repeat (10) @(negedge clk);
    sens = sens_en ? ~sens : 1'b0;
  end

  // Monitor: one scoreboard entry per completed flash frame.
  initial begin
    logic [23:0] e;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge csb);
      @(posedge csb);
      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_fetch: got addr %06h, expected no fetch", rx[23:0]);
      end else begin
        e = exp_q.pop_front();
        check("fetch_cmd", {24'd0, rx[31:24]}, 32'h03);
        check("fetch_addr", {8'd0, rx[23:0]}, {8'd0, e});
        check("glyph_out", {24'd0, uo_out}, {24'd0, fdata(e[7:0])});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enc_fwd();
    {enc_a, enc_b} = 2'b10; tick(1);
    {enc_a, enc_b} = 2'b11; tick(1);
    {enc_a, enc_b} = 2'b01; tick(1);
    {enc_a, enc_b} = 2'b00; tick(1);
  endtask

  task automatic enc_rev();
    {enc_a, enc_b} = 2'b01; tick(1);
    {enc_a, enc_b} = 2'b11; tick(1);
    {enc_a, enc_b} = 2'b10; tick(1);
    {enc_a, enc_b} = 2'b00; tick(1);
  endtask

  task automatic press(input int n);
    btn_n = 1'b0; tick(n);
    btn_n = 1'b1; tick(20);
  endtask

  // Wait (bounded) for the scoreboard to drain, then idle to expose extra fetches.
  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      tick(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout: %0d fetches outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick(120);
  endtask

  initial begin
    tick(5);
    check("rst_uo_out", {24'd0, uo_out}, 32'h00);
    check("rst_uio_out", {24'd0, uio_out}, 32'h20);
    check("rst_uio_oe", {24'd0, uio_oe}, 32'hB3);

    exp_q.push_back(24'h000000);
    rst_n = 1'b1;
    wait_done();
    check("mode_iso", {30'd0, uio_out[1:0]}, 32'd0);
    check("idle_csb_sck", {30'd0, uio_out[5:4]}, 32'h2);

    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(24'(i));
      enc_fwd();
      wait_done();
    end

    exp_q.push_back(24'h000010);
    press(100);
    wait_done();
    check("mode_ss", {30'd0, uio_out[1:0]}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(24'h000010 + 24'(i));
      enc_fwd();
      wait_done();
    end

    exp_q.push_back(24'h000020);
    press(100);
    wait_done();
    check("mode_f", {30'd0, uio_out[1:0]}, 32'd2);
    enc_rev();
    enc_rev();
    wait_done();

    // Enter metering: fetch on mode change, again at end of the gate window.
    exp_q.push_back(24'h000037);
    exp_q.push_back(24'h000037);
    press(400);
    wait_done();
    check("mode_exp", {30'd0, uio_out[1:0]}, 32'd3);

    exp_q.push_back(24'h000037);
    press(100);
    wait_done();
    check("mode_exp_remeasure", {30'd0, uio_out[1:0]}, 32'd3);

    // ~51 sensor edges per window -> EV 5 -> glyph 5+8-0+1-2 = 12.
    sens_en = 1'b1;
    exp_q.push_back(24'h00003C);
    press(100);
    wait_done();
    sens_en = 1'b0;
    check("mode_exp_sensor", {30'd0, uio_out[1:0]}, 32'd3);

    enc_fwd();
    wait_done();

    exp_q.push_back(24'h000004);
    press(400);
    wait_done();
    check("mode_back_iso", {30'd0, uio_out[1:0]}, 32'd0);

    for (int i = 5; i <= 15; i++) begin
      exp_q.push_back(24'(i));
      enc_fwd();
      wait_done();
    end
    enc_fwd();
    wait_done();
    check("final_idle_csb", {31'd0, csb}, 32'd1);
    check("final_uio_oe", {24'd0, uio_oe}, 32'hB3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
